// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file (regfile_mp).
// The XPR_LEN fallback mirrors rv32_opcodes.vh so the package also builds standalone.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int unsigned RF_XLEN      = `XPR_LEN;
    localparam int unsigned RF_MAX_PORTS = 8;
    localparam int unsigned RF_MAX_AW    = 8;

    typedef logic [RF_MAX_PORTS-1:0]                rf_wen_t;
    typedef logic [RF_MAX_PORTS-1:0][RF_MAX_AW-1:0] rf_waddr_t;

    // Highest-index enabled port addressing a wins; -1 when no port matches.
    function automatic int rf_win_port(input rf_wen_t en, input rf_waddr_t addr,
                                       input logic [RF_MAX_AW-1:0] a);
        int win;
        win = -1;
        for (int j = 0; j < int'(RF_MAX_PORTS); j++) begin
            if (en[j] && addr[j] == a) win = j;
        end
        return win;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: sweeps every entry once, then raises ready.
module rf_clear_seq import rf_pkg::*; #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          ready_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    rf_state_e     state_q;
    logic [AW-1:0] clr_ptr_q;
    logic          ready_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == AW'(NREGS - 1)) begin
                        state_q <= RF_READY;
                        ready_q <= 1'b1;
                    end
                end
                RF_READY: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign clr_we_o   = (state_q == RF_CLEAR) && rst_ni;
    assign clr_addr_o = clr_ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NREAD/NWRITE integer register file with hardware clear after reset.
// Define RF_BYPASS_EN to forward same-cycle writes to matching reads.
module regfile_mp import rf_pkg::*; #(
    parameter int unsigned  XLEN   = RF_XLEN,
    parameter int unsigned  NREGS  = 32,
    parameter int unsigned  NREAD  = 2,
    parameter int unsigned  NWRITE = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   ready_o,
    input  logic [NREAD*AW-1:0]    rs_addr_i,
    output logic [NREAD*XLEN-1:0]  rs_data_o,
    input  logic [NWRITE-1:0]      wr_en_i,
    input  logic [NWRITE*AW-1:0]   wr_addr_i,
    input  logic [NWRITE*XLEN-1:0] wr_data_i
);

    logic [XLEN-1:0] mem_q [NREGS];

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            wr_ok;
    rf_wen_t         we_pad;
    rf_waddr_t       wa_pad;
    logic            row_we    [NREGS];
    logic [XLEN-1:0] row_wdata [NREGS];

    rf_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ready_o    (ready_o),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // A reset edge in READY must drop the writes presented with it.
    assign wr_ok = ready_o && rst_ni;

    always_comb begin
        we_pad = '0;
        wa_pad = '0;
        for (int j = 0; j < int'(NWRITE); j++) begin
            we_pad[j]          = wr_en_i[j];
            wa_pad[j][AW-1:0]  = wr_addr_i[j*AW +: AW];
        end
    end

    always_comb begin
        int w;
        for (int r = 0; r < int'(NREGS); r++) begin
            row_we[r]    = 1'b0;
            row_wdata[r] = '0;
            w            = rf_win_port(we_pad, wa_pad, RF_MAX_AW'(r));
            if (wr_ok && r != 0 && w >= 0) begin
                row_we[r]    = 1'b1;
                row_wdata[r] = wr_data_i[w*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < int'(NREGS); r++) begin
            if (clr_we && clr_addr == AW'(r)) begin
                mem_q[r] <= '0;
            end else if (row_we[r]) begin
                mem_q[r] <= row_wdata[r];
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;
`ifdef RF_BYPASS_EN
        int              bw;
`endif
        ra        = '0;
        rv        = '0;
        rs_data_o = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            ra = rs_addr_i[i*AW +: AW];
            rv = mem_q[ra];
`ifdef RF_BYPASS_EN
            bw = rf_win_port(we_pad, wa_pad, RF_MAX_AW'(ra));
            if (bw >= 0) rv = wr_data_i[bw*XLEN +: XLEN];
`endif
            if (!ready_o || ra == '0) rv = '0;
            rs_data_o[i*XLEN +: XLEN] = rv;
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32 core, successor to the fixed 2-read/1-write file. It adds a configurable number of read and write ports, a synchronous hardware clear sequence after reset with a ready flag, and optional same-cycle write-to-read bypass. It sits between the decode stage (read ports) and the writeback stage (write ports).

## Interface
- XLEN, default `XPR_LEN (32): data width.
- NREGS, default 32: number of registers, power of two, at least 2.
- NREAD, default 2: read port count, at least 1.
- NWRITE, default 1: write port count, at least 1.
- AW, default $clog2(NREGS) (5, matching `REG_ADDR_WIDTH): address width (derived, not overridden).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ready  out  1  high once the clear sequence has completed.
- rs_addr  in  NREAD*AW  read addresses; port i is bits [i*AW +: AW].
- rs_data  out  NREAD*XLEN  read data; port i is bits [i*XLEN +: XLEN].
- wr_en  in  NWRITE  per-port write enable.
- wr_addr  in  NWRITE*AW  write addresses; port j is bits [j*AW +: AW].
- wr_data  in  NWRITE*XLEN  write data; port j is bits [j*XLEN +: XLEN].

## Operation
- **FSM states:** CLEAR and READY.
- **During reset:** rst_n low at a clock edge sets state to CLEAR, clr_ptr to 0, and ready to 0.
- **CLEAR:**
  - Each cycle with rst_n high writes 0 to entry clr_ptr, then increments clr_ptr.
  - When clr_ptr equals NREGS-1, that entry is cleared and state moves to READY.
  - The sequence takes exactly NREGS cycles after rst_n deasserts.
  - All wr_en inputs are ignored.
  - Every rs_data port reads 0.
- **READY:**
  - Reads are combinational: rs_data[i] = mem[rs_addr[i]].
  - Address 0 always reads 0.
  - Writes: wr_en[j] with wr_addr[j] != 0 updates mem[wr_addr[j]] at the clock edge. A write to address 0 is dropped.
  - Same-address writes in one cycle: the highest-index port wins. Lower ports are discarded.
  - Different-address writes in one cycle all commit.
- **Reset mid-clear:** clr_ptr restarts at 0 and the full NREGS-cycle sequence repeats.
- **Reset in READY:** re-enters CLEAR and discards any writes presented in that cycle.
- **State encoding:** 1 bit. clr_ptr is AW bits and is not wrapped; its exit is decoded at NREGS-1.

## Timing
- **Reset values:** ready = 0; rs_data = 0 on all ports; state = CLEAR; clr_ptr = 0.
- **Ready latency:** ready rises on the clock edge that clears entry NREGS-1. That is NREGS edges after the first edge with rst_n high (32 edges by default).
- **Read latency:** 0 cycles (combinational from rs_addr and mem).
- **Write latency:**
  - Without bypass, written data is visible on reads in the cycle after the write edge.
  - With bypass, it is visible in the same cycle the write is presented.
- **Simultaneous read and write, same address, no bypass:** the read returns the old value.
- **Handshake:** none. Upstream must hold writes until ready = 1. Writes presented before that are lost by design.

## Configuration
- **Macro:** RF_BYPASS_EN.
- **Defined:**
  - In READY, a read whose address matches an active write in the same cycle returns that write's wr_data.
  - Priority among matching ports follows the same rule: highest index wins.
  - Address 0 still reads 0.
  - Bypass is disabled during CLEAR.
- **Undefined:** reads return stored contents only. There is no combinational path from wr_data to rs_data.

## Structure
- **Shared package rf_pkg:**
  - State encoding constants RF_CLEAR and RF_READY.
  - A default-width localparam alias to `XPR_LEN.
  - A function computing the winning write port for an address.
- **Header:** `XPR_LEN and `REG_ADDR_WIDTH remain in rv32_opcodes.vh.
- **Sub-module rf_clear_seq:** holds the FSM and clr_ptr, and outputs ready, clr_we and clr_addr. The top mux gives clear-path writes priority.
- **Storage:** a plain reg array in the top; no vendor RAM macro.

## Test plan
- **Reset and clear:** hold rst_n low 3 cycles, then release → ready = 0 for exactly 32 edges, then 1. rs_data = 0 throughout. Every address reads 0 afterwards.
- **Basic write/read:** write 0xDEADBEEF to x5 → rs_addr[0] = 5 reads 0xDEADBEEF on the next cycle. Write 0x1234 to x0 → x0 reads 0.
- **Same-address write conflict:** NWRITE = 2, both ports write x7 with port0 = 0x1111 and port1 = 0x2222 → x7 reads 0x2222.
- **Same-cycle read-after-write on x9 (old 0xA, new 0xB):**
  - Without RF_BYPASS_EN → reads 0xA, then 0xB next cycle.
  - With RF_BYPASS_EN → reads 0xB in the same cycle.
- **Reset mid-clear:** assert rst_n low at clear cycle 10 for 1 cycle → ready rises 32 edges after re-release. A write of 0x55 to x3 during CLEAR is ignored and x3 reads 0.
- **Wide configuration:** NREAD = 4, NREGS = 64, XLEN = 64. Write 0x0123456789ABCDEF to x63 → all four read ports addressing 63 return the value, and x62 reads 0.
